mem_copy_engine: RTL and testbench

Block-copy engine that sits directly upstream of the single-port data memory and owns its address/enable/write-data port. When idle it passes the core's load/store port straight through to memory. On start it takes the port, copies LEN bytes from SRC to DST one byte at a time (read cycle, then write cycle) and signals done. Used to preload/relocate program data and to speed up memcpy-style test programs.

---
 rtl/mem_copy_engine_if.sv | 25 ++
 rtl/mem_copy_engine.sv | 121 ++++++++++++
 tb/tb_mem_copy_engine.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// Load/store port bundle shared by the core side and the data memory side
// of the copy engine. The requester drives address, enables and write data.
// The responder returns combinational read data.
interface mem_copy_engine_if #(
    parameter int W = 8,
    parameter int A = 8
);
    logic [A-1:0] addr;
    logic [W-1:0] wdata;
    logic         read_en;
    logic         write_en;
    logic [W-1:0] rdata;

    // Requester side: the core, or the engine facing the memory.
    modport master (
        output addr, wdata, read_en, write_en,
        input  rdata
    );

    // Responder side: the memory, or the engine facing the core.
    modport slave (
        input  addr, wdata, read_en, write_en,
        output rdata
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block-copy engine placed in front of the single-port data memory.
// When idle, the core's load/store port passes straight through to the memory.
// After a start, the engine takes the port and copies `length` bytes from
// src to dst in ascending order. Each byte takes one read cycle and one write
// cycle. A one-cycle done pulse follows the copy.
module mem_copy_engine #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [A-1:0]   src_addr,
    input  logic [A-1:0]   dst_addr,
    input  logic [A:0]     length,
    output logic           busy,
    output logic           done,
    mem_copy_engine_if.slave  cpu,
    mem_copy_engine_if.master mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t       state;
    logic [A-1:0] src_ptr;
    logic [A-1:0] dst_ptr;
    logic [A:0]   count;    // one bit wider than an address so a full 2**A copy fits
    logic [W-1:0] buffer;

    // Copy sequencer: the state, pointers, byte buffer and registered busy/done.
    // NOTE: every register here uses <=, so all right-hand sides see the
    // pre-edge values no matter in which order the statements are written.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            buffer  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        count   <= length;
                        if (length != '0) begin
                            state <= RD;
                            busy  <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    buffer  <= mem.rdata;
                    src_ptr <= src_ptr + A'(1);
                    state   <= WR;
                end
                WR: begin
                    dst_ptr <= dst_ptr + A'(1);
                    count   <= count - (A+1)'(1);
                    if (count == (A+1)'(1)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= RD;
                    end
                end
                default: begin
                    // FIN: the done pulse is already visible; fall back to idle.
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory port mux: passthrough unless copying, and fully quiet during reset.
    // NOTE: each output receives a default before the case statement. This
    // keeps the block purely combinational on every path, so no latch is inferred.
    always_comb begin
        mem.addr     = cpu.addr;
        mem.wdata    = cpu.wdata;
        mem.read_en  = cpu.read_en;
        mem.write_en = cpu.write_en;
        cpu.rdata    = mem.rdata;
        case (state)
            RD: begin
                mem.addr     = src_ptr;
                mem.wdata    = buffer;
                mem.read_en  = 1'b1;
                mem.write_en = 1'b0;
                cpu.rdata    = '0;
            end
            WR: begin
                mem.addr     = dst_ptr;
                mem.wdata    = buffer;
                mem.read_en  = 1'b0;
                mem.write_en = 1'b1;
                cpu.rdata    = '0;
            end
            default: ;
        endcase
        if (reset) begin
            mem.read_en  = 1'b0;
            mem.write_en = 1'b0;
            cpu.rdata    = '0;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine. A behavioural 256-byte memory sits behind the
// engine. A shadow image predicts the memory contents after every copy.
// Table-driven copies are followed by hand-written sequences for the
// passthrough, blocking, second-start and reset-abort cases.
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [8:0] length;
    logic       busy;
    logic       done;

    mem_copy_engine_if #(.W(8), .A(8)) cpu_bus ();
    mem_copy_engine_if #(.W(8), .A(8)) mem_bus ();

    mem_copy_engine #(.W(8), .A(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .cpu      (cpu_bus.slave),
        .mem      (mem_bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write at posedge.
    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    int         write_count = 0;

    assign mem_bus.rdata = mem[mem_bus.addr];

    always @(posedge clk) begin
        if (mem_bus.write_en) begin
            mem[mem_bus.addr] <= mem_bus.wdata;
            write_count <= write_count + 1;
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== exp_mem[i]) d++;
        return d;
    endfunction

    task automatic cpu_idle();
        cpu_bus.addr     = 8'h00;
        cpu_bus.wdata    = 8'h00;
        cpu_bus.read_en  = 1'b0;
        cpu_bus.write_en = 1'b0;
    endtask

    // Store one byte through the passthrough path. Call this at a negedge.
    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        cpu_bus.addr     = a;
        cpu_bus.wdata    = d;
        cpu_bus.write_en = 1'b1;
        @(negedge clk);
        cpu_bus.write_en = 1'b0;
    endtask

    // Shadow model of a strictly ascending byte copy with address wrap.
    task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
        logic [7:0] sp, dp;
        sp = s;
        dp = d;
        for (int i = 0; i < n; i++) begin
            exp_mem[dp] = exp_mem[sp];
            sp = sp + 8'd1;
            dp = dp + 8'd1;
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] src;
        logic [7:0] dst;
        logic [8:0] len;
        int         exp_busy;     // busy cycles
        int         exp_done_at;  // cycle after the start edge holding done
        logic [7:0] exp_last;     // hand-computed byte at dst+len-1
    } vec_t;

    vec_t vecs [5];

    task automatic run_copy(input vec_t v);
        int busy_cnt, done_cnt, done_at, w0, budget;
        @(negedge clk);
        start    = 1'b1;
        src_addr = v.src;
        dst_addr = v.dst;
        length   = v.len;
        w0       = write_count;
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        budget   = 2 * int'(v.len) + 4;
        for (int j = 1; j <= budget; j++) begin
            if (j > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = j;
            end
        end
        model_copy(v.src, v.dst, int'(v.len));
        check({v.name, "_busy_cycles"}, busy_cnt, v.exp_busy);
        check({v.name, "_done_cycle"}, done_at, v.exp_done_at);
        check({v.name, "_done_pulses"}, done_cnt, 1);
        check({v.name, "_writes"}, write_count - w0, int'(v.len));
        check({v.name, "_mem_image_diffs"}, mem_diffs(), 0);
        if (v.len != 9'd0)
            check({v.name, "_last_byte"}, mem[v.dst + v.len[7:0] - 8'd1], v.exp_last);
    endtask

    initial begin
        int done_cnt, w0;
        vecs[0] = '{"basic",   8'h20, 8'h40, 9'd4,   8,   9,   8'h04};
        vecs[1] = '{"zero",    8'h20, 8'h60, 9'd0,   0,   1,   8'h00};
        vecs[2] = '{"wrap",    8'hFE, 8'h10, 9'd4,   8,   9,   8'h22};
        vecs[3] = '{"overlap", 8'h50, 8'h51, 9'd3,   6,   7,   8'h07};
        vecs[4] = '{"full",    8'h00, 8'h00, 9'd256, 512, 513, 8'hCD};

        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        length   = 9'd0;
        cpu_bus.addr     = 8'h33;
        cpu_bus.wdata    = 8'h99;
        cpu_bus.read_en  = 1'b1;
        cpu_bus.write_en = 1'b1;

        // Reset gates the memory port regardless of the core's requests.
        @(negedge clk);
        check("rst_mem_write_en", mem_bus.write_en, 1'b0);
        check("rst_mem_read_en", mem_bus.read_en, 1'b0);
        check("rst_cpu_rdata", cpu_bus.rdata, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        cpu_idle();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        // Preload through the passthrough path: mem[i] = i plus marked bytes.
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i);
        exp_mem[8'h20] = 8'h01; exp_mem[8'h21] = 8'h02;
        exp_mem[8'h22] = 8'h03; exp_mem[8'h23] = 8'h04;
        exp_mem[8'hFE] = 8'hAB; exp_mem[8'hFF] = 8'hCD;
        exp_mem[8'h00] = 8'h11; exp_mem[8'h01] = 8'h22;
        exp_mem[8'h50] = 8'h07;
        for (int i = 0; i < 256; i++) cpu_write(8'(i), exp_mem[i]);

        // Passthrough store then load.
        cpu_write(8'h10, 8'hA5);
        exp_mem[8'h10] = 8'hA5;
        check("pt_busy_after_store", busy, 1'b0);
        cpu_bus.addr    = 8'h10;
        cpu_bus.read_en = 1'b1;
        #1;
        check("pt_load_data", cpu_bus.rdata, 8'hA5);
        check("pt_mem_read_en", mem_bus.read_en, 1'b1);
        check("pt_busy_during_load", busy, 1'b0);
        @(negedge clk);
        cpu_idle();
        check("preload_image_diffs", mem_diffs(), 0);

        for (int v = 0; v < 5; v++) run_copy(vecs[v]);

        // Core store during a copy is dropped; a second start is ignored.
        @(negedge clk);
        start = 1'b1; src_addr = 8'h20; dst_addr = 8'h70; length = 9'd4;
        done_cnt = 0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j == 1) begin
                cpu_bus.addr = 8'h80; cpu_bus.wdata = 8'hEE;
                cpu_bus.write_en = 1'b1; cpu_bus.read_en = 1'b1;
            end
            if (j == 3) begin
                start = 1'b1; src_addr = 8'h00; dst_addr = 8'h90; length = 9'd2;
            end
            if (j == 7) cpu_idle();
            #1;
            if (done) done_cnt++;
            if (j == 2) begin
                check("blk_cpu_rdata_wr", cpu_bus.rdata, 8'h00);
                check("blk_mem_read_en_wr", mem_bus.read_en, 1'b0);
            end
            if (j == 5) check("blk_cpu_rdata_rd", cpu_bus.rdata, 8'h00);
        end
        model_copy(8'h20, 8'h70, 4);
        check("blk_done_pulses", done_cnt, 1);
        check("blk_store_dropped", mem[8'h80], 8'h80);
        check("blk_second_start_ignored", mem[8'h90], 8'h90);
        check("blk_mem_image_diffs", mem_diffs(), 0);

        // Reset after the third write cycle of an 8-byte copy.
        @(negedge clk);
        start = 1'b1; src_addr = 8'h20; dst_addr = 8'hA0; length = 9'd8;
        w0 = write_count;
        done_cnt = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j == 7) begin
                reset = 1'b1;
                #1;
                check("abort_mem_read_en_in_reset", mem_bus.read_en, 1'b0);
            end
            if (j == 8) begin
                reset = 1'b0;
                #1;
                check("abort_busy_after_reset", busy, 1'b0);
            end
            if (done) done_cnt++;
        end
        model_copy(8'h20, 8'hA0, 3);
        check("abort_no_done", done_cnt, 0);
        check("abort_write_count", write_count - w0, 3);
        check("abort_mem_image_diffs", mem_diffs(), 0);

        // Passthrough still works after the abort.
        cpu_write(8'hA7, 8'h3C);
        cpu_bus.addr    = 8'hA7;
        cpu_bus.read_en = 1'b1;
        #1;
        check("abort_pt_load", cpu_bus.rdata, 8'h3C);
        @(negedge clk);
        cpu_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
